// File: rtl/lbm_pkg.sv
// -----------------------------------------------------------------------------
// lbm_pkg
// Shared types for the lattice-Boltzmann distribution storage.
//   NUM_DIR / DIR_WIDTH : default D2Q9 lattice, 32-bit signed distributions
//   dist_t              : one signed distribution value
//   dist_vec_t          : one node's full distribution vector (lane 0 in LSBs)
//   dist_ram_state_t    : initialisation sequencer states
// -----------------------------------------------------------------------------
package lbm_pkg;

    localparam int NUM_DIR   = 9;
    localparam int DIR_WIDTH = 32;

    typedef logic signed [DIR_WIDTH-1:0] dist_t;
    typedef dist_t [NUM_DIR-1:0] dist_vec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } dist_ram_state_t;

endpackage

// File: rtl/dist_lane_ram.sv
// -----------------------------------------------------------------------------
// dist_lane_ram
// One lane of the distribution store: simple-dual-port DEPTH x DIR_WIDTH RAM,
// synchronous write, registered read. The read register only loads when re is
// high, so rdata holds the last value read between reads.
// Ports:
//   Clk            clock (rising edge)
//   we/waddr/wdata write port
//   re/raddr       read port request
//   rdata          registered read data (one cycle after re)
// The contents and the read register are deliberately not reset so the array
// maps onto block RAM.
// -----------------------------------------------------------------------------
module dist_lane_ram #(
    parameter int DEPTH         = 256,
    parameter int ADDRESS_WIDTH = 8,
    parameter int DIR_WIDTH     = 32
) (
    input  logic                     Clk,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [DIR_WIDTH-1:0]     wdata,
    input  logic                     re,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    output logic [DIR_WIDTH-1:0]     rdata
);
    import lbm_pkg::*;

    logic [DIR_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DIR_WIDTH-1:0] rdata_reg;

    // Read-before-write on a same-address collision: the read samples the
    // array before the non-blocking write lands.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/lbm_dist_ram.sv
// -----------------------------------------------------------------------------
// lbm_dist_ram
// Simple-dual-port store for lattice-Boltzmann distribution vectors, one node
// per address, NUM_DIR signed lanes of DIR_WIDTH bits each. Sits between the
// collision and streaming stages.
//
// Ports:
//   Clk, Reset            clock / asynchronous active-high reset
//   init_start            start filling every node with init_value
//   init_value            equilibrium vector, sampled every fill cycle
//   busy                  fill in progress (FILL and DONE states)
//   init_done             one-cycle pulse at the end of the fill
//   wr_en/wr_addr/wr_mask/wr_data   masked write port (ignored while busy)
//   rd_en/rd_addr         read request (ignored while busy)
//   rd_data/rd_valid      read result, RD_LATENCY (1 or 2) cycles after request
//
// Build option: define LBM_DIST_RAM_BYPASS_EN to forward same-cycle,
// same-address write data into the read result (per masked lane). Without it
// a colliding read returns the old contents.
// Out-of-range addresses (only possible when DEPTH is not a power of two)
// drop writes and read back as zero with rd_valid asserted.
// -----------------------------------------------------------------------------
module lbm_dist_ram #(
    parameter int NUM_DIR       = 9,
    parameter int DIR_WIDTH     = 32,
    parameter int DEPTH         = 256,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH    = NUM_DIR * DIR_WIDTH,
    parameter int RD_LATENCY    = 1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     init_start,
    input  logic [DATA_WIDTH-1:0]    init_value,
    output logic                     busy,
    output logic                     init_done,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [NUM_DIR-1:0]       wr_mask,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_valid
);
    import lbm_pkg::*;

    // ------------------------------------------------------------------
    // Initialisation sequencer
    // ------------------------------------------------------------------
    dist_ram_state_t          state_reg;
    dist_ram_state_t          state_next;
    logic [ADDRESS_WIDTH-1:0] cnt_reg;
    logic                     fill_last;
    logic                     fill_we;

    assign fill_last = (cnt_reg == ADDRESS_WIDTH'(DEPTH - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == FILL && !fill_last) begin
                cnt_reg <= cnt_reg + ADDRESS_WIDTH'(1);
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (init_start) state_next = FILL;
            FILL:    if (fill_last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        init_done = 1'b0;
        fill_we   = 1'b0;
        case (state_reg)
            FILL: begin
                busy    = 1'b1;
                fill_we = 1'b1;
            end
            DONE: begin
                busy      = 1'b1;
                init_done = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    logic wr_in_range;
    logic rd_in_range;
    logic user_wr;
    logic rd_accept;

    // One extra bit so the compare is meaningful when DEPTH == 2**ADDRESS_WIDTH.
    assign wr_in_range = ({1'b0, wr_addr} < (ADDRESS_WIDTH + 1)'(DEPTH));
    assign rd_in_range = ({1'b0, rd_addr} < (ADDRESS_WIDTH + 1)'(DEPTH));
    assign user_wr     = wr_en & ~busy & wr_in_range;
    assign rd_accept   = rd_en & ~busy;

    // ------------------------------------------------------------------
    // Lane RAMs: the fill owns the write port while it runs
    // ------------------------------------------------------------------
    logic [NUM_DIR-1:0]       lane_we;
    logic [DATA_WIDTH-1:0]    lane_wdata;
    logic [ADDRESS_WIDTH-1:0] lane_waddr;
    logic [DATA_WIDTH-1:0]    ram_q;

    assign lane_waddr = fill_we ? cnt_reg : wr_addr;

    for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_lane
        assign lane_we[gi] = fill_we | (user_wr & wr_mask[gi]);
        assign lane_wdata[gi*DIR_WIDTH +: DIR_WIDTH] =
            fill_we ? init_value[gi*DIR_WIDTH +: DIR_WIDTH]
                    : wr_data[gi*DIR_WIDTH +: DIR_WIDTH];

        dist_lane_ram #(
            .DEPTH         (DEPTH),
            .ADDRESS_WIDTH (ADDRESS_WIDTH),
            .DIR_WIDTH     (DIR_WIDTH)
        ) u_lane_ram (
            .Clk   (Clk),
            .we    (lane_we[gi]),
            .waddr (lane_waddr),
            .wdata (lane_wdata[gi*DIR_WIDTH +: DIR_WIDTH]),
            .re    (rd_accept),
            .raddr (rd_addr),
            .rdata (ram_q[gi*DIR_WIDTH +: DIR_WIDTH])
        );
    end

    // ------------------------------------------------------------------
    // Read stage 1: side-band captured alongside the RAM read register.
    // Everything here loads only on an accepted read, so the merged
    // result below holds between reads. s1_zero_reg resets high so
    // rd_data reads zero out of reset without touching the RAM register.
    // ------------------------------------------------------------------
    logic                  s1_valid_reg;
    logic                  s1_zero_reg;
    logic [DATA_WIDTH-1:0] s1_merged;
    logic [DATA_WIDTH-1:0] s1_data;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_valid_reg <= 1'b0;
            s1_zero_reg  <= 1'b1;
        end else begin
            s1_valid_reg <= rd_accept;
            if (rd_accept) begin
                s1_zero_reg <= ~rd_in_range;
            end
        end
    end

`ifdef LBM_DIST_RAM_BYPASS_EN
    // Same-address collision: remember which lanes were written and with
    // what, then substitute them over the (pre-write) RAM output.
    logic [NUM_DIR-1:0]    s1_byp_mask_reg;
    logic [DATA_WIDTH-1:0] s1_byp_data_reg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_byp_mask_reg <= '0;
            s1_byp_data_reg <= '0;
        end else if (rd_accept) begin
            s1_byp_mask_reg <= (user_wr && (wr_addr == rd_addr)) ? wr_mask : '0;
            s1_byp_data_reg <= wr_data;
        end
    end

    for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_bypass
        assign s1_merged[gi*DIR_WIDTH +: DIR_WIDTH] =
            s1_byp_mask_reg[gi] ? s1_byp_data_reg[gi*DIR_WIDTH +: DIR_WIDTH]
                                : ram_q[gi*DIR_WIDTH +: DIR_WIDTH];
    end
`else
    assign s1_merged = ram_q;
`endif

    assign s1_data = s1_zero_reg ? '0 : s1_merged;

    // ------------------------------------------------------------------
    // Optional output register for RD_LATENCY == 2
    // ------------------------------------------------------------------
    if (RD_LATENCY == 2) begin : g_lat2
        logic                  s2_valid_reg;
        logic [DATA_WIDTH-1:0] s2_data_reg;

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                s2_valid_reg <= 1'b0;
                s2_data_reg  <= '0;
            end else begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_data_reg <= s1_data;
                end
            end
        end

        assign rd_valid = s2_valid_reg;
        assign rd_data  = s2_data_reg;
    end else begin : g_lat1
        assign rd_valid = s1_valid_reg;
        assign rd_data  = s1_data;
    end

endmodule

// File: tb/tb_lbm_dist_ram.sv
// -----------------------------------------------------------------------------
// tb_lbm_dist_ram
// Drives one RD_LATENCY=1 and one RD_LATENCY=2 instance with shared stimulus.
// Table-driven write/read vectors plus hand-written sequences for the fill,
// the aborted fill, back-to-back reads and reset with reads in flight.
// -----------------------------------------------------------------------------
module tb_lbm_dist_ram;
    localparam int NUM_DIR   = 9;
    localparam int DIR_WIDTH = 32;
    localparam int DEPTH     = 256;
    localparam int AW        = 8;
    localparam int DW        = NUM_DIR * DIR_WIDTH;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          init_start;
    logic [DW-1:0] init_value;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [NUM_DIR-1:0] wr_mask;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    logic          busy1, busy2, done1, done2, valid1, valid2;
    logic [DW-1:0] data1, data2;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model [0:DEPTH-1];

    always #5 Clk = ~Clk;

    lbm_dist_ram #(.NUM_DIR(NUM_DIR), .DIR_WIDTH(DIR_WIDTH), .DEPTH(DEPTH), .RD_LATENCY(1)) dut_l1 (
        .Clk(Clk), .Reset(Reset), .init_start(init_start), .init_value(init_value),
        .busy(busy1), .init_done(done1), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_mask(wr_mask), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(data1), .rd_valid(valid1)
    );

    lbm_dist_ram #(.NUM_DIR(NUM_DIR), .DIR_WIDTH(DIR_WIDTH), .DEPTH(DEPTH), .RD_LATENCY(2)) dut_l2 (
        .Clk(Clk), .Reset(Reset), .init_start(init_start), .init_value(init_value),
        .busy(busy2), .init_done(done2), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_mask(wr_mask), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(data2), .rd_valid(valid2)
    );

    typedef struct {
        string          name;
        logic           we;
        logic [AW-1:0]  wa;
        logic [8:0]     wm;
        logic [DW-1:0]  wd;
        logic           re;
        logic [AW-1:0]  ra;
        logic [DW-1:0]  exp;
    } vec_t;

    vec_t tbl [0:14];

    function automatic logic [DW-1:0] splat(input logic [31:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < NUM_DIR; i++) r[i*32 +: 32] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] ramp();
        logic [DW-1:0] r;
        for (int i = 0; i < NUM_DIR; i++) r[i*32 +: 32] = 32'(i + 1);
        return r;
    endfunction

    function automatic logic [DW-1:0] set_lane(input logic [DW-1:0] v, input int lane,
                                               input logic [31:0] val);
        logic [DW-1:0] r;
        r = v;
        r[lane*32 +: 32] = val;
        return r;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] last_exp;
        int busy_cnt, fill_cnt, done_cnt, done_at, done2_at, spurious, ended, seen;

        Reset = 1'b1; init_start = 1'b0; init_value = '0;
        wr_en = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0;
        repeat (3) tick();
        Reset = 1'b0;
        tick();

        // Reset state
        chk("reset_busy",   DW'(busy1),  '0);
        chk("reset_done",   DW'(done1),  '0);
        chk("reset_valid1", DW'(valid1), '0);
        chk("reset_valid2", DW'(valid2), '0);
        chk("reset_data1",  data1,       '0);
        chk("reset_data2",  data2,       '0);
        $display("reset: busy=%0b done=%0b v1=%0b v2=%0b", busy1, done1, valid1, valid2);

        // Fill aborted by reset at fill cycle 100
        init_value = splat(32'h0BAD0BAD);
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        chk("abort_busy_start", DW'(busy1), DW'(1));
        repeat (99) tick();
        Reset = 1'b1;
        #1;
        chk("abort_busy1",  DW'(busy1),  '0);
        chk("abort_busy2",  DW'(busy2),  '0);
        chk("abort_valid1", DW'(valid1), '0);
        chk("abort_valid2", DW'(valid2), '0);
        tick();
        Reset = 1'b0;
        seen = 0;
        repeat (200) begin
            tick();
            if (busy1 || busy2 || done1 || done2) seen++;
        end
        chk("abort_no_done", DW'(seen), '0);
        $display("aborted fill: activity cycles after reset=%0d", seen);

        // Full fill; write, read and init_start during the fill are ignored
        init_value = ramp();
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        busy_cnt = 0; fill_cnt = 0; done_cnt = 0; done_at = 0; done2_at = 0;
        spurious = 0; ended = 0;
        for (int c = 1; c <= 400; c++) begin
            if (busy1) busy_cnt++;
            if (busy1 && !done1) fill_cnt++;
            if (done1) begin done_cnt++; done_at = c; end
            if (done2) done2_at = c;
            if (valid1 || valid2) spurious++;
            if (!busy1 && c > 1) begin ended = 1; break; end
            wr_en      = (c == 200);
            wr_addr    = 8'd7;
            wr_mask    = '1;
            wr_data    = splat(32'hDEADBEEF);
            rd_en      = (c == 200);
            rd_addr    = 8'd7;
            init_start = (c == 150);
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b0; init_start = 1'b0;
        chk("fill_ended",       DW'(ended),    DW'(1));
        chk("fill_cycles",      DW'(fill_cnt), DW'(256));
        chk("fill_busy_cycles", DW'(busy_cnt), DW'(257));
        chk("fill_done_count",  DW'(done_cnt), DW'(1));
        chk("fill_done_cycle",  DW'(done_at),  DW'(257));
        chk("fill_done2_cycle", DW'(done2_at), DW'(257));
        chk("fill_no_rd_valid", DW'(spurious), '0);
        $display("fill: fill_cycles=%0d busy_cycles=%0d done_at=%0d", fill_cnt, busy_cnt, done_at);
        for (int a = 0; a < DEPTH; a++) model[a] = ramp();

        // Directed vectors
        tbl[0]  = '{"rd_addr0",   1'b0, 8'd0,  9'h000, '0, 1'b1, 8'd0,   ramp()};
        tbl[1]  = '{"rd_addr17",  1'b0, 8'd0,  9'h000, '0, 1'b1, 8'd17,  ramp()};
        tbl[2]  = '{"rd_addr255", 1'b0, 8'd0,  9'h000, '0, 1'b1, 8'd255, ramp()};
        tbl[3]  = '{"rd_addr7",   1'b0, 8'd0,  9'h000, '0, 1'b1, 8'd7,   ramp()};
        tbl[4]  = '{"wr5_all",    1'b1, 8'd5,  9'h1FF, splat(32'hFFFFFFFF), 1'b0, 8'd0, '0};
        tbl[5]  = '{"wr5_lane1",  1'b1, 8'd5,  9'h002, set_lane('0, 1, 32'h7FFFFFFF), 1'b0, 8'd0, '0};
        tbl[6]  = '{"rd_addr5",   1'b0, 8'd0,  9'h000, '0, 1'b1, 8'd5,
                    set_lane(splat(32'hFFFFFFFF), 1, 32'h7FFFFFFF)};
        tbl[7]  = '{"wr3_zero",   1'b1, 8'd3,  9'h1FF, '0, 1'b0, 8'd0, '0};
`ifdef LBM_DIST_RAM_BYPASS_EN
        tbl[8]  = '{"wr_rd3_coll", 1'b1, 8'd3, 9'h1FF, splat(32'h55555555), 1'b1, 8'd3,
                    splat(32'h55555555)};
        tbl[10] = '{"wr_rd9_part", 1'b1, 8'd9, 9'h101, splat(32'hAAAAAAAA), 1'b1, 8'd9,
                    set_lane(set_lane(ramp(), 0, 32'hAAAAAAAA), 8, 32'hAAAAAAAA)};
`else
        tbl[8]  = '{"wr_rd3_coll", 1'b1, 8'd3, 9'h1FF, splat(32'h55555555), 1'b1, 8'd3, '0};
        tbl[10] = '{"wr_rd9_part", 1'b1, 8'd9, 9'h101, splat(32'hAAAAAAAA), 1'b1, 8'd9, ramp()};
`endif
        tbl[9]  = '{"rd_addr3",   1'b0, 8'd0,  9'h000, '0, 1'b1, 8'd3,  splat(32'h55555555)};
        tbl[11] = '{"wr10_rd11",  1'b1, 8'd10, 9'h1FF, splat(32'h80000000), 1'b1, 8'd11, ramp()};
        tbl[12] = '{"rd_addr10",  1'b0, 8'd0,  9'h000, '0, 1'b1, 8'd10, splat(32'h80000000)};
        tbl[13] = '{"wr12_nomask", 1'b1, 8'd12, 9'h000, splat(32'h12345678), 1'b0, 8'd0, '0};
        tbl[14] = '{"rd_addr12",  1'b0, 8'd0,  9'h000, '0, 1'b1, 8'd12, ramp()};

        last_exp = '0;
        for (int k = 0; k <= 14; k++) begin
            wr_en = tbl[k].we; wr_addr = tbl[k].wa; wr_mask = tbl[k].wm; wr_data = tbl[k].wd;
            rd_en = tbl[k].re; rd_addr = tbl[k].ra;
            tick();
            wr_en = 1'b0; rd_en = 1'b0;
            if (tbl[k].we)
                for (int i = 0; i < NUM_DIR; i++)
                    if (tbl[k].wm[i]) model[tbl[k].wa][i*32 +: 32] = tbl[k].wd[i*32 +: 32];
            chk({tbl[k].name, "_valid1"}, DW'(valid1), DW'(tbl[k].re));
            chk({tbl[k].name, "_data1"}, data1, tbl[k].re ? tbl[k].exp : last_exp);
            chk({tbl[k].name, "_early2"}, DW'(valid2), '0);
            tick();
            chk({tbl[k].name, "_valid2"}, DW'(valid2), DW'(tbl[k].re));
            chk({tbl[k].name, "_data2"}, data2, tbl[k].re ? tbl[k].exp : last_exp);
            chk({tbl[k].name, "_drop1"}, DW'(valid1), '0);
            $display("vec %s: we=%0b wa=%0d wm=%h re=%0b ra=%0d v1=%0b v2=%0b",
                     tbl[k].name, tbl[k].we, tbl[k].wa, tbl[k].wm, tbl[k].re, tbl[k].ra,
                     valid1, valid2);
            if (tbl[k].re) last_exp = tbl[k].exp;
        end

        // Back-to-back reads of addresses 0..15
        for (int t = 0; t < 20; t++) begin
            rd_en   = (t < 16);
            rd_addr = 8'(t);
            tick();
            chk($sformatf("burst_valid1_t%0d", t), DW'(valid1), DW'(t < 16));
            if (t < 16) chk($sformatf("burst_data1_t%0d", t), data1, model[t]);
            chk($sformatf("burst_valid2_t%0d", t), DW'(valid2), DW'(t >= 1 && t < 17));
            if (t >= 1 && t < 17) chk($sformatf("burst_data2_t%0d", t), data2, model[t-1]);
            $display("burst t=%0d: v1=%0b v2=%0b", t, valid1, valid2);
        end
        rd_en = 1'b0;

        // Reset with reads in flight
        rd_en = 1'b1; rd_addr = 8'd5;
        tick();
        rd_en = 1'b0;
        chk("flight_valid1_pre", DW'(valid1), DW'(1));
        Reset = 1'b1;
        #1;
        chk("flight_valid1", DW'(valid1), '0);
        chk("flight_data1",  data1,       '0);
        tick();
        chk("flight_valid2", DW'(valid2), '0);
        chk("flight_data2",  data2,       '0);
        Reset = 1'b0;
        tick();
        chk("flight_valid2_after", DW'(valid2), '0);
        $display("reset in flight: v1=%0b v2=%0b", valid1, valid2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
